// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: an in-order FIFO with first-word fall-through,
// early-mispredict squash with a held redirect to fetch, and a backend flush that overrides all.
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_pre_pc,
    input  logic          in_pre_direction,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   instr,
    output logic [31:0]   pc,
    output logic [31:0]   pre_pc,
    output logic          pre_direction,
    input  logic          detect_first_result,
    input  logic [31:0]   dec_target,
    input  logic          be_flush,
    output logic          redirect_valid,
    output logic [31:0]   redirect_pc,
    input  logic          redirect_ready,
    output logic [AW:0]   count
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_REDIR = 1'b1;

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Payload storage is intentionally not reset; it is only observed while out_valid is high.
    logic [31:0] instr_mem  [DEPTH];
    logic [31:0] pc_mem     [DEPTH];
    logic [31:0] pre_pc_mem [DEPTH];
    logic        dir_mem    [DEPTH];

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          redirect_valid_q, redirect_valid_d;
    logic [31:0]   redirect_pc_q, redirect_pc_d;

    logic pop;
    logic push;
    logic mispredict;

    assign out_valid  = (count_q != '0);
    assign pop        = out_valid & out_ready;
    assign mispredict = pop & ~detect_first_result;

    // in_ready looks only at current occupancy, so a pop at full never frees a slot that cycle.
    assign in_ready = (state_q == ST_RUN) & (count_q < FULL_CNT) & ~be_flush & ~mispredict;
    assign push     = in_valid & in_ready;

    assign instr          = instr_mem[rd_ptr_q];
    assign pc             = pc_mem[rd_ptr_q];
    assign pre_pc         = pre_pc_mem[rd_ptr_q];
    assign pre_direction  = dir_mem[rd_ptr_q];
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign count          = count_q;

    always_comb begin
        state_d          = state_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        count_d          = count_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;

        if (be_flush) begin
            // The backend redirect is older than anything held here, including a pending redirect.
            state_d          = ST_RUN;
            rd_ptr_d         = '0;
            wr_ptr_d         = '0;
            count_d          = '0;
            redirect_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mispredict) begin
                        state_d          = ST_REDIR;
                        rd_ptr_d         = '0;
                        wr_ptr_d         = '0;
                        count_d          = '0;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = dec_target;
                    end else begin
                        if (push) begin
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                        end
                        if (pop) begin
                            rd_ptr_d = rd_ptr_q + PTR_ONE;
                        end
                        case ({push, pop})
                            2'b10:   count_d = count_q + CNT_ONE;
                            2'b01:   count_d = count_q - CNT_ONE;
                            default: count_d = count_q;
                        endcase
                    end
                end
                ST_REDIR: begin
                    if (redirect_valid_q & redirect_ready) begin
                        state_d          = ST_RUN;
                        redirect_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_RUN;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q]  <= in_instr;
            pc_mem[wr_ptr_q]     <= in_pc;
            pre_pc_mem[wr_ptr_q] <= in_pre_pc;
            dir_mem[wr_ptr_q]    <= in_pre_direction;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a vector table for fill/drain, directed redirect/flush/reset sequences,
// and a randomized phase checked against a queue-based model of the buffer.
module tb_fetch_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    // valid/ready: a transfer happens on any rising edge where both valid and ready are high.
    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc;
    logic [31:0]   in_pre_pc;
    logic          in_pre_direction;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [31:0]   pre_pc;
    logic          pre_direction;
    logic          detect_first_result;
    logic [31:0]   dec_target;
    logic          be_flush;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          redirect_ready;
    logic [AW:0]   count;

    fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_instr            (in_instr),
        .in_pc               (in_pc),
        .in_pre_pc           (in_pre_pc),
        .in_pre_direction    (in_pre_direction),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .instr               (instr),
        .pc                  (pc),
        .pre_pc              (pre_pc),
        .pre_direction       (pre_direction),
        .detect_first_result (detect_first_result),
        .dec_target          (dec_target),
        .be_flush            (be_flush),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .redirect_ready      (redirect_ready),
        .count               (count)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pre_pc;
        logic        dir;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        logic        iv;
        logic [31:0] ipc;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [3:0]  e_cnt;
        logic [31:0] e_pc;
    } vec_t;
    vec_t vecs[18];

    function automatic vec_t mk(input int iv, input int ipc, input int ordy,
                                input int e_cnt, input int e_ir, input int e_ov, input int e_pc);
        vec_t v;
        v.iv    = (iv != 0);
        v.ipc   = 32'(ipc);
        v.ordy  = (ordy != 0);
        v.e_cnt = 4'(e_cnt);
        v.e_ir  = (e_ir != 0);
        v.e_ov  = (e_ov != 0);
        v.e_pc  = 32'(e_pc);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid            = 1'b0;
        in_instr            = '0;
        in_pc               = '0;
        in_pre_pc           = '0;
        in_pre_direction    = 1'b0;
        out_ready           = 1'b0;
        detect_first_result = 1'b1;
        dec_target          = '0;
        be_flush            = 1'b0;
        redirect_ready      = 1'b0;
    endtask

    // Payload fields are derived from pc so order checks also catch mixed-up fields.
    task automatic set_in(input logic v, input logic [31:0] p);
        in_valid         = v;
        in_pc            = p;
        in_instr         = ~p;
        in_pre_pc        = p + 32'd8;
        in_pre_direction = p[2];
    endtask

    task automatic push_one(input logic [31:0] p);
        idle();
        set_in(1'b1, p);
        tick();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_clean(input string nm);
        idle();
        #1;
        chk({nm, "_count"}, 32'(count), 32'd0);
        chk({nm, "_rv"}, 32'(redirect_valid), 32'd0);
        chk({nm, "_ov"}, 32'(out_valid), 32'd0);
        chk({nm, "_ir"}, 32'(in_ready), 32'd1);
    endtask

    task automatic make_redir(input logic [31:0] base, input int n, input logic [31:0] tgt);
        for (int i = 0; i < n; i++) push_one(base + 32'(4 * i));
        idle();
        out_ready           = 1'b1;
        detect_first_result = 1'b0;
        dec_target          = tgt;
        tick();
    endtask

    // ---------------- test ----------------
    initial begin
        for (int i = 0; i < 8; i++) vecs[i] = mk(1, 'h100 + 4 * i, 0, i, 1, (i != 0) ? 1 : 0, 'h100);
        vecs[8] = mk(1, 'h120, 0, 8, 0, 1, 'h100);
        for (int k = 0; k < 8; k++) vecs[9 + k] = mk(0, 0, 1, 8 - k, (k != 0) ? 1 : 0, 1, 'h100 + 4 * k);
        vecs[17] = mk(0, 0, 1, 0, 1, 0, 0);

        rst = 1'b1;
        idle();
        repeat (2) tick();
        rst = 1'b0;

        #1;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_ir", 32'(in_ready), 32'd1);
        chk("reset_ov", 32'(out_valid), 32'd0);
        chk("reset_rv", 32'(redirect_valid), 32'd0);
        chk("reset_rpc", redirect_pc, 32'd0);

        // Fill to full, attempt a push at full, then drain in order.
        for (int i = 0; i < 18; i++) begin
            idle();
            set_in(vecs[i].iv, vecs[i].ipc);
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("tab%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("tab%0d_ir", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("tab%0d_ov", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("tab%0d_rv", i), 32'(redirect_valid), 32'd0);
            if (vecs[i].e_ov) begin
                chk($sformatf("tab%0d_pc", i), pc, vecs[i].e_pc);
                chk($sformatf("tab%0d_instr", i), instr, ~vecs[i].e_pc);
            end
            tick();
        end

        // Steady occupancy of 4 with concurrent push/pop across the pointer wrap.
        for (int i = 0; i < 4; i++) begin
            push_one(32'h400 + 32'(4 * i));
            exp_q.push_back(32'h400 + 32'(4 * i));
        end
        for (int j = 0; j < 20; j++) begin
            idle();
            set_in(1'b1, 32'h500 + 32'(4 * j));
            out_ready = 1'b1;
            #1;
            chk("wrap_count", 32'(count), 32'd4);
            chk("wrap_ir", 32'(in_ready), 32'd1);
            chk("wrap_pc", pc, exp_q[0]);
            chk("wrap_pre_pc", pre_pc, exp_q[0] + 32'd8);
            chk("wrap_dir", 32'(pre_direction), 32'(exp_q[0][2]));
            void'(exp_q.pop_front());
            exp_q.push_back(32'h500 + 32'(4 * j));
            tick();
        end
        while (exp_q.size() != 0) begin
            idle();
            out_ready = 1'b1;
            #1;
            chk("drain_ov", 32'(out_valid), 32'd1);
            chk("drain_pc", pc, exp_q.pop_front());
            tick();
        end
        chk_clean("drain_end");

        // Early mispredict with the redirect held for three cycles.
        for (int i = 0; i < 5; i++) push_one(32'h200 + 32'(4 * i));
        idle();
        set_in(1'b1, 32'h777);
        out_ready           = 1'b1;
        detect_first_result = 1'b0;
        dec_target          = 32'h340;
        #1;
        chk("mis_head_pc", pc, 32'h200);
        chk("mis_ir", 32'(in_ready), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            set_in(1'b1, 32'h888);
            #1;
            chk("redir_count", 32'(count), 32'd0);
            chk("redir_rv", 32'(redirect_valid), 32'd1);
            chk("redir_rpc", redirect_pc, 32'h340);
            chk("redir_ir", 32'(in_ready), 32'd0);
            chk("redir_ov", 32'(out_valid), 32'd0);
            tick();
        end
        idle();
        redirect_ready = 1'b1;
        #1;
        chk("redir_hs_rv", 32'(redirect_valid), 32'd1);
        tick();
        chk_clean("redir_done");

        // be_flush in REDIR, alone and together with redirect_ready.
        for (int r = 0; r < 2; r++) begin
            make_redir(32'h520, 2, 32'h540);
            idle();
            be_flush       = 1'b1;
            redirect_ready = (r == 1);
            #1;
            chk("fl_redir_ir", 32'(in_ready), 32'd0);
            chk("fl_redir_rv", 32'(redirect_valid), 32'd1);
            tick();
            chk_clean("fl_redir");
        end

        // be_flush in RUN with a push and a mispredicting pop in the same cycle.
        for (int i = 0; i < 3; i++) push_one(32'h600 + 32'(4 * i));
        idle();
        set_in(1'b1, 32'h700);
        out_ready           = 1'b1;
        detect_first_result = 1'b0;
        dec_target          = 32'h6F0;
        be_flush            = 1'b1;
        #1;
        chk("fl_run_ir", 32'(in_ready), 32'd0);
        tick();
        chk_clean("fl_run");

        // Push-into-empty latency: not visible in cycle N, visible in N+1.
        idle();
        set_in(1'b1, 32'h900);
        #1;
        chk("lat_ov_n", 32'(out_valid), 32'd0);
        tick();
        idle();
        out_ready = 1'b1;
        #1;
        chk("lat_ov_n1", 32'(out_valid), 32'd1);
        chk("lat_pc", pc, 32'h900);
        chk("lat_instr", instr, ~32'h900);
        tick();

        // Reset mid-REDIR, then mid-RUN at count 6.
        make_redir(32'h980, 1, 32'hABC);
        do_reset();
        chk_clean("rst_redir");
        chk("rst_redir_rpc", redirect_pc, 32'd0);
        for (int i = 0; i < 6; i++) push_one(32'hA00 + 32'(4 * i));
        idle();
        #1;
        chk("rst_run_pre_count", 32'(count), 32'd6);
        do_reset();
        chk_clean("rst_run");

        // Randomized traffic against the queue model.
        begin
            logic m_redir;
            logic [31:0] m_rpc;
            logic e_ov, e_pop, e_mis, e_ir;
            m_redir = 1'b0;
            m_rpc   = '0;
            mq.delete();
            for (int c = 0; c < 3000; c++) begin
                idle();
                set_in(($urandom_range(0, 9) < 7), $urandom);
                out_ready           = ($urandom_range(0, 1) == 1);
                detect_first_result = ($urandom_range(0, 7) != 0);
                dec_target          = $urandom;
                be_flush            = ($urandom_range(0, 39) == 0);
                redirect_ready      = ($urandom_range(0, 1) == 1);
                rst                 = ($urandom_range(0, 299) == 0);
                #1;
                e_ov  = (mq.size() != 0);
                e_pop = e_ov & out_ready;
                e_mis = e_pop & ~detect_first_result;
                e_ir  = ~m_redir & (mq.size() < DEPTH) & ~be_flush & ~e_mis;
                chk("rnd_count", 32'(count), 32'(mq.size()));
                chk("rnd_ov", 32'(out_valid), 32'(e_ov));
                chk("rnd_ir", 32'(in_ready), 32'(e_ir));
                chk("rnd_rv", 32'(redirect_valid), 32'(m_redir));
                if (m_redir) chk("rnd_rpc", redirect_pc, m_rpc);
                if (e_ov) begin
                    chk("rnd_pc", pc, mq[0].pc);
                    chk("rnd_instr", instr, mq[0].instr);
                    chk("rnd_pre_pc", pre_pc, mq[0].pre_pc);
                    chk("rnd_dir", 32'(pre_direction), 32'(mq[0].dir));
                end
                if (rst) begin
                    mq.delete();
                    m_redir = 1'b0;
                    m_rpc   = '0;
                end else if (be_flush) begin
                    mq.delete();
                    m_redir = 1'b0;
                end else if (!m_redir) begin
                    if (e_mis) begin
                        mq.delete();
                        m_redir = 1'b1;
                        m_rpc   = dec_target;
                    end else begin
                        if (e_pop) void'(mq.pop_front());
                        if (in_valid && e_ir)
                            mq.push_back('{instr: in_instr, pc: in_pc, pre_pc: in_pre_pc, dir: in_pre_direction});
                    end
                end else if (redirect_ready) begin
                    m_redir = 1'b0;
                end
                tick();
            end
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and the instruction decoder.
- Stores fetched instructions with their pc, predicted next pc and predicted direction, and presents them to the decoder in order over a valid/ready handshake.
- Consumes the decoder's early prediction check (detect_first_result). On a detected mispredict it drops all younger wrong-path entries and issues a held redirect request to fetch.
- A backend flush overrides everything.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
AW, 3, pointer width, log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch presents an entry
in_ready  out  1  queue accepts an entry this cycle
in_instr  in  32  fetched instruction
in_pc  in  32  pc of instruction
in_pre_pc  in  32  predicted next pc
in_pre_direction  in  1  predicted taken
out_valid  out  1  head entry valid
out_ready  in  1  decoder consumes head
instr  out  32  head instruction
pc  out  32  head pc
pre_pc  out  32  head predicted next pc
pre_direction  out  1  head predicted taken
detect_first_result  in  1  decoder check for the consumed head; 0 = mispredict
dec_target  in  32  corrected next pc for the consumed head, from decode
be_flush  in  1  backend flush
redirect_valid  out  1  early redirect request to fetch
redirect_pc  out  32  early redirect target
redirect_ready  in  1  fetch accepts the redirect
count  out  AW+1  occupied entries

Behaviour:
- Reset: state RUN, rd_ptr = wr_ptr = 0, count = 0, redirect_valid = 0, redirect_pc = 0. in_ready = 1 in the cycle after reset; out_valid = 0. Payload storage is not reset; data outputs are don't-care while out_valid = 0.
- Storage: circular buffer. Pointers are AW bits and wrap DEPTH-1 -> 0. count tracks occupancy 0..DEPTH.
- Output mode: first-word fall-through. instr/pc/pre_pc/pre_direction come combinationally from entry[rd_ptr]. out_valid = (count != 0).
- Latency: an entry pushed at edge N is visible at the outputs from cycle N+1. There is no same-cycle bypass.
- Push: occurs when in_valid & in_ready.
- Pop: occurs when out_valid & out_ready.
- in_ready = (state == RUN) & (count < DEPTH) & !be_flush & !mispredict.
  - mispredict = pop & !detect_first_result.
  - At full, in_ready is low even if a pop occurs in the same cycle.
- Simultaneous push and pop (count strictly between 0 and DEPTH): count is unchanged and both pointers advance.
- Push into an empty queue while out_valid = 0: no pop occurs in that cycle.
- detect_first_result and dec_target are sampled only on a pop cycle and ignored otherwise.
- State RUN:
  - be_flush = 1: at the next edge, pointers reset to 0 and count = 0. Any push or pop in that cycle is discarded or ignored, the mispredict check is ignored, and the state stays RUN.
  - Else, mispredict: the popped head is consumed normally. All remaining entries are dropped at the next edge (pointers to 0, count = 0). Any push that cycle is blocked because in_ready = 0. redirect_pc <= dec_target, redirect_valid <= 1, and the state goes to REDIR.
  - Else: normal push/pop.
- State REDIR:
  - in_ready = 0, and the queue stays empty (out_valid = 0).
  - redirect_valid and redirect_pc are held stable until redirect_ready.
  - When redirect_valid & redirect_ready: at the next edge, redirect_valid = 0 and the state goes to RUN.
  - be_flush in REDIR has priority over redirect_ready. It clears redirect_valid and returns to RUN, because the backend redirect is older.
- Reset mid-operation: returns to reset values at the next edge regardless of state or pending redirect.
- The queue never overflows or underflows; pushes at full and pops at empty cannot occur by construction.

Test Plan:
- Fill/drain, DEPTH=8: push 8 entries with pc 0x100..0x11C and out_ready = 0 -> count = 8, in_ready = 0. Then set out_ready = 1 -> pc appears 0x100..0x11C in order, count reaches 0, out_valid drops.
- Wrap and concurrency: hold count = 4 while pushing and popping every cycle for 20 cycles -> count stays 4, output order matches input order across the pointer wrap, no entry lost or duplicated.
- Early mispredict: 5 entries queued, pop head pc = 0x200 with detect_first_result = 0 and dec_target = 0x340 -> next cycle count = 0, redirect_valid = 1, redirect_pc = 0x340, in_ready = 0. Hold redirect_ready = 0 for 3 cycles -> outputs stable. Then redirect_ready = 1 -> the cycle after, redirect_valid = 0 and in_ready = 1.
- Backend flush priority: in REDIR, assert be_flush and redirect_ready together -> next cycle redirect_valid = 0, state RUN, count = 0. Separately, in RUN assert be_flush with push, and pop with detect_first_result = 0 -> count = 0 and no redirect issued.
- Latency: push into an empty queue at cycle N -> out_valid = 0 in cycle N, out_valid = 1 with the pushed payload in cycle N+1.
- Reset: assert rst mid-REDIR with count = 0, and mid-RUN with count = 6 -> the next cycle count = 0, redirect_valid = 0, out_valid = 0, in_ready = 1.
